// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared widths and arbiter state encoding for the SPI register arbiter
package spi_reg_pkg;

  localparam int ADR_W  = 10;
  localparam int DAT_W  = 16;
  localparam int CNTR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BG_ACC  = 2'd1,
    ST_SPI_OWN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/spi_reg_arb_starve.sv
// rtl/spi_reg_arb_starve.sv - saturating wait counter raising a sticky starvation flag
// Cleared only by a grant or reset.
module spi_reg_arb_starve
  import spi_reg_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic sclk_i,
  input  logic resetb,
  input  logic i_wait,
  input  logic i_gnt,
  output logic o_starve
);

  localparam logic [CNTR_W-1:0] MAX_C = CNTR_W'(STARVE_MAX);

  logic [CNTR_W-1:0] r_cnt;
  logic [CNTR_W-1:0] w_cnt_nxt;
  logic              r_starve;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_wait && (r_cnt != '1))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge sclk_i or negedge resetb) begin
    if (!resetb) begin
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else if (i_gnt) begin
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt >= MAX_C)
        r_starve <= 1'b1;
    end
  end

  assign o_starve = r_starve;

endmodule

// File: rtl/spi_reg_arb.sv
// rtl/spi_reg_arb.sv - register-file arbiter between SPI slave and a background requester
// Starvation detection is compiled in with SPI_REG_ARB_STARVE_EN.
module spi_reg_arb
  import spi_reg_pkg::*;
#(
  parameter int ACC_CYC    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        sclk_i,
  input  logic        resetb,
  input  logic        spi_busy_i,
  input  logic        spi_ce_i,
  input  logic        spi_we_i,
  input  logic [9:0]  spi_addr_i,
  input  logic [15:0] spi_wdata_i,
  input  logic        bg_req_i,
  input  logic        bg_we_i,
  input  logic [9:0]  bg_addr_i,
  input  logic [15:0] bg_wdata_i,
  output logic        bg_gnt_o,
  output logic        bg_done_o,
  output logic        bg_abort_o,
  output logic [15:0] bg_rdata_o,
  output logic        bg_starve_o,
  output logic        rf_ce_o,
  output logic        rf_we_o,
  output logic [9:0]  rf_addr_o,
  output logic [15:0] rf_wdata_o,
  input  logic [15:0] rf_rdata_i,
  output logic        rf_own_o,
  output logic        conflict_o
);

  localparam logic [2:0] LAST_CYC = 3'(ACC_CYC - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [2:0]        r_cyc;
  logic              r_bg_we;
  logic [ADR_W-1:0]  r_bg_addr;
  logic [DAT_W-1:0]  r_bg_wdata;
  logic [ADR_W-1:0]  r_last_addr;
  logic [DAT_W-1:0]  r_last_wdata;
  logic [DAT_W-1:0]  r_rdata;
  logic              r_gnt;
  logic              r_done;
  logic              r_abort;
  logic              r_conflict;

  logic w_spi_act;
  logic w_grant;
  logic w_last;
  logic w_abort;
  logic w_pass;

  assign w_spi_act = spi_busy_i | spi_ce_i;
  assign w_grant   = (r_state == ST_IDLE) && !w_spi_act && bg_req_i;
  assign w_abort   = (r_state == ST_BG_ACC) && spi_ce_i;
  assign w_last    = (r_state == ST_BG_ACC) && (r_cyc == LAST_CYC);
  // An SPI strobe during a background access takes the port in the same cycle.
  assign w_pass    = (r_state == ST_SPI_OWN) || w_abort;

  always_ff @(posedge sclk_i or negedge resetb) begin
    if (!resetb)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_spi_act)
          w_next = ST_SPI_OWN;
        else if (bg_req_i)
          w_next = ST_BG_ACC;
      end
      ST_BG_ACC: begin
        if (spi_ce_i)
          w_next = ST_SPI_OWN;
        else if (w_last)
          w_next = ST_IDLE;
      end
      ST_SPI_OWN: begin
        if (!w_spi_act)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_own_o   = w_pass;
    rf_ce_o    = 1'b0;
    rf_we_o    = 1'b0;
    rf_addr_o  = r_last_addr;
    rf_wdata_o = r_last_wdata;
    if (w_pass) begin
      rf_ce_o    = spi_ce_i;
      rf_we_o    = spi_we_i;
      rf_addr_o  = spi_addr_i;
      rf_wdata_o = spi_wdata_i;
    end else if (r_state == ST_BG_ACC) begin
      rf_ce_o    = 1'b1;
      rf_we_o    = r_bg_we;
      rf_addr_o  = r_bg_addr;
      rf_wdata_o = r_bg_wdata;
    end
  end

  always_ff @(posedge sclk_i or negedge resetb) begin
    if (!resetb) begin
      r_cyc        <= '0;
      r_bg_we      <= 1'b0;
      r_bg_addr    <= '0;
      r_bg_wdata   <= '0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_rdata      <= 16'hffff;
      r_gnt        <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_conflict   <= 1'b0;
    end else begin
      r_last_addr  <= rf_addr_o;
      r_last_wdata <= rf_wdata_o;
      r_gnt        <= w_grant;
      r_done       <= w_abort | w_last;
      r_abort      <= w_abort;
      if (w_abort)
        r_conflict <= 1'b1;
      if (w_grant) begin
        r_cyc      <= '0;
        r_bg_we    <= bg_we_i;
        r_bg_addr  <= bg_addr_i;
        r_bg_wdata <= bg_wdata_i;
      end else if (r_state == ST_BG_ACC) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (w_last && !w_abort && !r_bg_we)
        r_rdata <= rf_rdata_i;
    end
  end

  assign bg_gnt_o   = r_gnt;
  assign bg_done_o  = r_done;
  assign bg_abort_o = r_abort;
  assign bg_rdata_o = r_rdata;
  assign conflict_o = r_conflict;

`ifdef SPI_REG_ARB_STARVE_EN
  logic w_wait;
  assign w_wait = bg_req_i && (r_state != ST_BG_ACC) && !w_grant;

  spi_reg_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .sclk_i   (sclk_i),
    .resetb   (resetb),
    .i_wait   (w_wait),
    .i_gnt    (w_grant),
    .o_starve (bg_starve_o)
  );
`else
  assign bg_starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_arb.sv
// tb/tb_spi_reg_arb.sv - directed self-checking bench for spi_reg_arb
module tb_spi_reg_arb;

`ifdef SPI_REG_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        sclk_i = 1'b0;
  logic        resetb;
  logic        spi_busy_i, spi_ce_i, spi_we_i;
  logic [9:0]  spi_addr_i;
  logic [15:0] spi_wdata_i;
  logic        bg_req_i, bg_we_i;
  logic [9:0]  bg_addr_i;
  logic [15:0] bg_wdata_i;
  logic        bg_gnt_o, bg_done_o, bg_abort_o, bg_starve_o;
  logic [15:0] bg_rdata_o;
  logic        rf_ce_o, rf_we_o, rf_own_o, conflict_o;
  logic [9:0]  rf_addr_o;
  logic [15:0] rf_wdata_o;
  logic [15:0] rf_rdata_i;

  int n_err = 0;
  int n_chk = 0;

  spi_reg_arb #(.ACC_CYC(2), .STARVE_MAX(8)) dut (
    .sclk_i      (sclk_i),
    .resetb      (resetb),
    .spi_busy_i  (spi_busy_i),
    .spi_ce_i    (spi_ce_i),
    .spi_we_i    (spi_we_i),
    .spi_addr_i  (spi_addr_i),
    .spi_wdata_i (spi_wdata_i),
    .bg_req_i    (bg_req_i),
    .bg_we_i     (bg_we_i),
    .bg_addr_i   (bg_addr_i),
    .bg_wdata_i  (bg_wdata_i),
    .bg_gnt_o    (bg_gnt_o),
    .bg_done_o   (bg_done_o),
    .bg_abort_o  (bg_abort_o),
    .bg_rdata_o  (bg_rdata_o),
    .bg_starve_o (bg_starve_o),
    .rf_ce_o     (rf_ce_o),
    .rf_we_o     (rf_we_o),
    .rf_addr_o   (rf_addr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rf_rdata_i  (rf_rdata_i),
    .rf_own_o    (rf_own_o),
    .conflict_o  (conflict_o)
  );

  always #5 sclk_i = ~sclk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sclk_i);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_gnt"},      32'(bg_gnt_o),    32'h0);
    check({pfx, "_done"},     32'(bg_done_o),   32'h0);
    check({pfx, "_abort"},    32'(bg_abort_o),  32'h0);
    check({pfx, "_starve"},   32'(bg_starve_o), 32'h0);
    check({pfx, "_conflict"}, 32'(conflict_o),  32'h0);
    check({pfx, "_ce"},       32'(rf_ce_o),     32'h0);
    check({pfx, "_we"},       32'(rf_we_o),     32'h0);
    check({pfx, "_own"},      32'(rf_own_o),    32'h0);
    check({pfx, "_addr"},     32'(rf_addr_o),   32'h0);
    check({pfx, "_wdata"},    32'(rf_wdata_o),  32'h0);
    check({pfx, "_rdata"},    32'(bg_rdata_o),  32'hffff);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetb = 1'b0;
    spi_busy_i = 0; spi_ce_i = 0; spi_we_i = 0; spi_addr_i = '0; spi_wdata_i = '0;
    bg_req_i = 0; bg_we_i = 0; bg_addr_i = '0; bg_wdata_i = '0; rf_rdata_i = '0;
    step();
    check_reset("por");
    resetb = 1'b1;
    step();

    // background read
    bg_req_i = 1; bg_we_i = 0; bg_addr_i = 10'h05A; bg_wdata_i = 16'h1234; rf_rdata_i = 16'hBEEF;
    #1;
    check("rd_gnt_pre", 32'(bg_gnt_o), 32'h0);
    step();
    check("rd_gnt", 32'(bg_gnt_o), 32'h1);
    check("rd_ce1", 32'(rf_ce_o), 32'h1);
    check("rd_addr", 32'(rf_addr_o), 32'h05A);
    check("rd_we", 32'(rf_we_o), 32'h0);
    check("rd_own", 32'(rf_own_o), 32'h0);
    bg_req_i = 0;
    step();
    check("rd_gnt_pulse", 32'(bg_gnt_o), 32'h0);
    check("rd_ce2", 32'(rf_ce_o), 32'h1);
    check("rd_done_early", 32'(bg_done_o), 32'h0);
    step();
    check("rd_done", 32'(bg_done_o), 32'h1);
    check("rd_rdata", 32'(bg_rdata_o), 32'hBEEF);
    check("rd_ce_idle", 32'(rf_ce_o), 32'h0);
    check("rd_addr_hold", 32'(rf_addr_o), 32'h05A);
    step();
    check("rd_done_pulse", 32'(bg_done_o), 32'h0);

    // background write leaves read data untouched
    bg_req_i = 1; bg_we_i = 1; bg_addr_i = 10'h3C1; bg_wdata_i = 16'hA5A5; rf_rdata_i = 16'h0000;
    step();
    check("wr_we", 32'(rf_we_o), 32'h1);
    check("wr_wdata", 32'(rf_wdata_o), 32'hA5A5);
    check("wr_addr", 32'(rf_addr_o), 32'h3C1);
    bg_req_i = 0;
    step();
    step();
    check("wr_done", 32'(bg_done_o), 32'h1);
    check("wr_rdata_hold", 32'(bg_rdata_o), 32'hBEEF);
    step();

    // request held through done starts a second access
    bg_req_i = 1; bg_we_i = 0; bg_addr_i = 10'h011; rf_rdata_i = 16'h0042;
    step();
    check("b2b_gnt1", 32'(bg_gnt_o), 32'h1);
    step();
    step();
    check("b2b_done1", 32'(bg_done_o), 32'h1);
    check("b2b_rdata", 32'(bg_rdata_o), 32'h0042);
    step();
    check("b2b_gnt2", 32'(bg_gnt_o), 32'h1);
    bg_req_i = 0;
    step();
    step();
    check("b2b_done2", 32'(bg_done_o), 32'h1);
    step();

    // SPI busy and request on the same edge: SPI wins
    spi_busy_i = 1; bg_req_i = 1; spi_addr_i = 10'h2AA; spi_wdata_i = 16'h5555;
    bg_addr_i = 10'h111; rf_rdata_i = 16'hCAFE;
    #1;
    check("sim_own_pre", 32'(rf_own_o), 32'h0);
    step();
    check("sim_own", 32'(rf_own_o), 32'h1);
    check("sim_nogrant", 32'(bg_gnt_o), 32'h0);
    check("sim_addr", 32'(rf_addr_o), 32'h2AA);
    check("sim_wdata", 32'(rf_wdata_o), 32'h5555);
    check("sim_ce", 32'(rf_ce_o), 32'h0);
    spi_busy_i = 0;
    step();
    check("sim_own_off", 32'(rf_own_o), 32'h0);
    check("sim_gnt_wait", 32'(bg_gnt_o), 32'h0);
    check("sim_addr_hold", 32'(rf_addr_o), 32'h2AA);
    step();
    check("sim_gnt", 32'(bg_gnt_o), 32'h1);
    check("sim_bg_addr", 32'(rf_addr_o), 32'h111);
    bg_req_i = 0;
    step();
    step();
    check("sim_done", 32'(bg_done_o), 32'h1);
    check("sim_rdata", 32'(bg_rdata_o), 32'hCAFE);
    step();

    // request dropped before grant is ignored
    spi_busy_i = 1; bg_req_i = 1;
    step();
    bg_req_i = 0;
    step();
    spi_busy_i = 0;
    step();
    step();
    check("drop_nogrant", 32'(bg_gnt_o), 32'h0);
    check("drop_ce", 32'(rf_ce_o), 32'h0);

    // SPI strobe on first access cycle aborts
    bg_req_i = 1; bg_we_i = 0; bg_addr_i = 10'h077;
    step();
    check("ab_gnt", 32'(bg_gnt_o), 32'h1);
    spi_ce_i = 1; spi_we_i = 1; spi_addr_i = 10'h155; spi_wdata_i = 16'h0F0F; bg_req_i = 0;
    #1;
    check("ab_addr", 32'(rf_addr_o), 32'h155);
    check("ab_wdata", 32'(rf_wdata_o), 32'h0F0F);
    check("ab_ce", 32'(rf_ce_o), 32'h1);
    check("ab_we", 32'(rf_we_o), 32'h1);
    check("ab_own", 32'(rf_own_o), 32'h1);
    step();
    check("ab_abort", 32'(bg_abort_o), 32'h1);
    check("ab_done", 32'(bg_done_o), 32'h1);
    check("ab_conflict", 32'(conflict_o), 32'h1);
    check("ab_rdata_hold", 32'(bg_rdata_o), 32'hCAFE);
    check("ab_own_after", 32'(rf_own_o), 32'h1);
    spi_ce_i = 0; spi_we_i = 0;
    step();
    check("ab_abort_pulse", 32'(bg_abort_o), 32'h0);
    check("ab_done_pulse", 32'(bg_done_o), 32'h0);
    check("ab_conflict_sticky", 32'(conflict_o), 32'h1);
    check("ab_idle_own", 32'(rf_own_o), 32'h0);

    // SPI busy rising mid-access does not interrupt
    bg_req_i = 1; bg_addr_i = 10'h0AB; rf_rdata_i = 16'h1357;
    step();
    check("bz_gnt", 32'(bg_gnt_o), 32'h1);
    spi_busy_i = 1; bg_req_i = 0;
    #1;
    check("bz_own0", 32'(rf_own_o), 32'h0);
    check("bz_ce", 32'(rf_ce_o), 32'h1);
    step();
    check("bz_addr", 32'(rf_addr_o), 32'h0AB);
    check("bz_own1", 32'(rf_own_o), 32'h0);
    step();
    check("bz_done", 32'(bg_done_o), 32'h1);
    check("bz_rdata", 32'(bg_rdata_o), 32'h1357);
    check("bz_idle_own", 32'(rf_own_o), 32'h0);
    step();
    check("bz_spi_own", 32'(rf_own_o), 32'h1);
    spi_busy_i = 0;
    step();

    // starvation under a long SPI burst
    spi_busy_i = 1; bg_req_i = 1; spi_addr_i = 10'h000;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("stv_wait%0d", k), 32'(bg_starve_o), 32'(STARVE_ON && (k >= 8)));
    end
    spi_addr_i = 10'h3FF;
    #1;
    check("stv_pass_addr", 32'(rf_addr_o), 32'h3FF);
    spi_busy_i = 0;
    step();
    check("stv_sticky", 32'(bg_starve_o), 32'(STARVE_ON));
    check("stv_nogrant", 32'(bg_gnt_o), 32'h0);
    step();
    check("stv_gnt", 32'(bg_gnt_o), 32'h1);
    check("stv_clear", 32'(bg_starve_o), 32'h0);
    bg_req_i = 0;
    step();
    step();
    check("stv_done", 32'(bg_done_o), 32'h1);
    step();

    // reset in the middle of an access
    bg_req_i = 1; bg_addr_i = 10'h200; rf_rdata_i = 16'h9999;
    step();
    check("rst_ce_before", 32'(rf_ce_o), 32'h1);
    bg_req_i = 0;
    #1;
    resetb = 1'b0;
    #1;
    check_reset("rst");
    step();
    check("rst_nodone1", 32'(bg_done_o), 32'h0);
    step();
    check("rst_nodone2", 32'(bg_done_o), 32'h0);
    resetb = 1'b1;
    step();
    check("rst_nodone3", 32'(bg_done_o), 32'h0);
    check("rst_ce_after", 32'(rf_ce_o), 32'h0);
    check("rst_rdata_after", 32'(bg_rdata_o), 32'hffff);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_reg_arb.md
SPI_REG_ARB -- requirements
Module: spi_reg_arb

Interface
REQ-001 SHALL have parameter ACC_CYC, default 2, meaning background register access length in sclk_i cycles, legal 1..6.
REQ-002 SHALL have parameter STARVE_MAX, default 8, meaning the number of waiting cycles before the starvation flag sets, legal 1..63.
REQ-003 SHALL have port sclk_i, input, 1 bit: clock; all state advances on its rising edge.
REQ-004 SHALL have port resetb, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports spi_busy_i, spi_ce_i and spi_we_i, input, 1 bit each: SPI slave fence and access strobes.
REQ-006 SHALL have ports spi_addr_i (10 bits) and spi_wdata_i (16 bits), input: SPI slave address and write data.
REQ-007 SHALL have ports bg_req_i and bg_we_i, input, 1 bit each: background request level and write select.
REQ-008 SHALL have ports bg_addr_i (10 bits) and bg_wdata_i (16 bits), input: background address and write data.
REQ-009 SHALL have ports bg_gnt_o, bg_done_o and bg_abort_o, output, 1 bit each: single-cycle pulses.
REQ-010 SHALL have port bg_rdata_o, output, 16 bits: background read result.
REQ-011 SHALL have port bg_starve_o, output, 1 bit: sticky starvation flag.
REQ-012 SHALL have ports rf_ce_o, rf_we_o (1 bit), rf_addr_o (10 bits) and rf_wdata_o (16 bits), output: register-file port.
REQ-013 SHALL have port rf_rdata_i, input, 16 bits: register-file read data.
REQ-014 SHALL have ports rf_own_o (1 bit, 1 = SPI owns the register file) and conflict_o (1 bit, sticky), output.

Function
REQ-015 SHALL implement the FSM states IDLE, BG_ACC and SPI_OWN.
REQ-016 In IDLE, if spi_busy_i or spi_ce_i is high, the FSM SHALL go to SPI_OWN; else if bg_req_i is high, it SHALL go to BG_ACC, latch bg_addr_i, bg_we_i and bg_wdata_i, and pulse bg_gnt_o on the next cycle.
REQ-017 When spi_busy_i and bg_req_i are high in the same IDLE cycle, SPI SHALL win and no grant SHALL issue.
REQ-018 In BG_ACC, rf_ce_o SHALL stay 1 for exactly ACC_CYC cycles, with rf_we_o, rf_addr_o and rf_wdata_o taken from the latched fields.
REQ-019 On the last BG_ACC cycle, rf_rdata_i SHALL be captured into bg_rdata_o (reads only; writes leave it unchanged), bg_done_o SHALL pulse, and the FSM SHALL go to IDLE.
REQ-020 spi_busy_i rising during BG_ACC SHALL NOT interrupt the access; SPI_OWN SHALL be entered from IDLE on the following cycle.
REQ-021 spi_ce_i high during BG_ACC SHALL abort the access: bg_abort_o and bg_done_o pulse, bg_rdata_o holds, conflict_o sets, and the FSM goes to SPI_OWN.
REQ-022 In SPI_OWN, rf_* SHALL be combinational passthrough of spi_*, with zero added latency, and rf_own_o SHALL be 1.
REQ-023 SPI_OWN SHALL exit to IDLE on the first cycle where spi_busy_i and spi_ce_i are both low.
REQ-024 In IDLE, rf_ce_o and rf_we_o SHALL be 0, and rf_addr_o and rf_wdata_o SHALL hold their last values.
REQ-025 A request dropped before grant SHALL be ignored, and bg_req_i held after bg_done_o SHALL start a new access.
REQ-026 The starvation counter (6 bits, saturating) SHALL count cycles in which bg_req_i is high and no grant occurs, clear on bg_gnt_o, and set bg_starve_o at STARVE_MAX.
REQ-027 bg_starve_o SHALL clear only on grant or reset.

Reset
REQ-028 On resetb low, the FSM SHALL go to IDLE.
REQ-029 On resetb low, bg_gnt_o, bg_done_o, bg_abort_o, bg_starve_o, conflict_o, rf_ce_o, rf_we_o and rf_own_o SHALL be 0.
REQ-030 On resetb low, rf_addr_o SHALL be 10'h0, rf_wdata_o 16'h0, bg_rdata_o 16'hffff, and the counters 0.
REQ-031 Reset mid-BG_ACC SHALL discard the access with no bg_done_o pulse.

Configuration
REQ-032 The macro SPI_REG_ARB_STARVE_EN SHALL control starvation detection.
REQ-033 With SPI_REG_ARB_STARVE_EN defined, the starvation counter and bg_starve_o logic SHALL be compiled in.
REQ-034 Without SPI_REG_ARB_STARVE_EN, bg_starve_o SHALL be tied 0 and no counter SHALL exist.

Structure
REQ-035 The shared package spi_reg_pkg SHALL hold ADR_W=10, DAT_W=16, CNTR_W=6, the arbiter state typedef and its encodings.
REQ-036 The starvation counter SHALL be the sub-module spi_reg_arb_starve, instantiated only under SPI_REG_ARB_STARVE_EN.

Verification
REQ-037 Read scenario: bg_req_i=1, bg_we_i=0, bg_addr_i=10'h05A, rf_rdata_i=16'hBEEF in IDLE -> bg_gnt_o next cycle, rf_ce_o high for 2 cycles, bg_rdata_o=16'hBEEF, bg_done_o pulse.
REQ-038 Simultaneous scenario: spi_busy_i=1 and bg_req_i=1 on the same edge -> rf_own_o=1, no bg_gnt_o, and after busy falls the grant issues on the next cycle.
REQ-039 Abort scenario: spi_ce_i=1 on the first BG_ACC cycle -> bg_abort_o and bg_done_o pulse, conflict_o=1, and rf_addr_o equals spi_addr_i in the same cycle.
REQ-040 Starvation scenario: spi_busy_i held for 10 cycles with bg_req_i=1 and STARVE_MAX=8 -> bg_starve_o=1 after the 8th waiting cycle, cleared at grant, and 0 throughout without the macro.
REQ-041 Reset scenario: resetb pulsed low during BG_ACC -> all outputs at reset values, bg_rdata_o=16'hffff, no bg_done_o pulse.
